// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : dmem_port_arbiter
// Brief   : Shares the single-ported DMEM between the CPU MEM stage (fixed
//           priority) and a DMA/debug master with starvation-bounded stalls.
// Revision: 1.0 - initial release
// ============================================================================
module dmem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 8,
    parameter int WAIT_W   = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_access,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_wait  = 2'd1;
    localparam logic [1:0] c_st_stall = 2'd2;
    localparam logic [1:0] c_st_ack   = 2'd3;

    localparam logic [WAIT_W-1:0] c_max_wait = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] c_cnt_one  = WAIT_W'(1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [WAIT_W-1:0] r_cnt;
    logic [WAIT_W-1:0] w_cnt_nxt;
    logic [WAIT_W-1:0] w_cnt_inc;
    logic              w_arb_open;
    logic              w_dma_grant;
    logic              r_dma_ack;
    logic [DATA_W-1:0] r_dma_rdata;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_cnt       <= '0;
            r_dma_ack   <= 1'b0;
            r_dma_rdata <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_dma_ack <= w_dma_grant;
            if (w_dma_grant) begin
                r_dma_rdata <= mem_rdata;
            end
        end
    end

    always_comb begin
        w_arb_open  = (r_state == c_st_idle) || (r_state == c_st_wait);
        w_dma_grant = dma_req & ((w_arb_open & ~cpu_access) | (r_state == c_st_stall));
        w_cnt_inc   = r_cnt + c_cnt_one;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_st_idle, c_st_wait: begin
                if (!dma_req) begin
                    w_state_nxt = c_st_idle;
                    w_cnt_nxt   = '0;
                end else if (!cpu_access) begin
                    w_state_nxt = c_st_ack;
                    w_cnt_nxt   = '0;
                end else begin
                    // Stall is forced on the MAX_WAIT-th blocked cycle, so cnt never passes MAX_WAIT
                    w_cnt_nxt   = w_cnt_inc;
                    w_state_nxt = (w_cnt_inc == c_max_wait) ? c_st_stall : c_st_wait;
                end
            end
            c_st_stall: begin
                w_state_nxt = c_st_ack;
                w_cnt_nxt   = '0;
            end
            default: begin
                w_state_nxt = c_st_idle;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        cpu_stall = (r_state == c_st_stall);
        cpu_rdata = mem_rdata;
        dma_ack   = r_dma_ack;
        dma_rdata = r_dma_rdata;
        if (w_dma_grant) begin
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            mem_we    = dma_we;
        end else begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_we    = cpu_we & cpu_access;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_dmem_port_arbiter
// Brief   : Vector table, directed corner sequences and a randomized run
//           against a transaction-level reference for dmem_port_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dmem_port_arbiter;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 8;
    localparam int WAIT_W   = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              cpu_access, cpu_we, cpu_stall;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
    logic              dma_req, dma_we, dma_ack;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata, dma_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic              mem_we;

    dmem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W)
    ) dut (
        .clock(clock), .reset(reset),
        .cpu_access(cpu_access), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    // Data memory model with a side preload port
    logic [31:0] dmem [0:255];
    logic        pl_en = 1'b0;
    logic [7:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;
    always @(posedge clock) begin
        if (pl_en) dmem[pl_addr] <= pl_data;
        else if (mem_we) dmem[mem_addr[7:0]] <= mem_wdata;
    end
    assign mem_rdata = dmem[mem_addr[7:0]];

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic ca, cw, dr, dw;
        logic exp_we, exp_dma;
    } vec_t;
    vec_t vecs[7];

    logic [31:0] ref_mem [0:255];
    bit          m_ack_cycle, m_stall, m_grant, hold_cpu, dma_pending;
    int          m_blocked;
    logic        m_ack_exp, e_we;
    logic [31:0] m_rdata_exp, e_addr, e_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_idle();
        cpu_access = 1'b0; cpu_we = 1'b0; dma_req = 1'b0; dma_we = 1'b0;
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        @(negedge clock);
        chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
        chk("rst_ack", {31'd0, dma_ack}, 32'd0);
        chk("rst_rdata", dma_rdata, 32'd0);
        chk("rst_addr", mem_addr, cpu_addr);
        reset = 1'b0;
        tick();
    endtask

    // CPU hammers DMEM while the DMA writes 0x40; optional reset in the stall cycle
    task automatic scen3(input bit do_rst, input logic [31:0] d);
        cpu_access = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h48;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h40; dma_wdata = d;
        for (int c = 0; c < MAX_WAIT; c++) begin
            @(negedge clock);
            chk("s3_cpu_owns", mem_addr, 32'h48);
            chk("s3_no_stall", {31'd0, cpu_stall}, 32'd0);
            tick();
        end
        @(negedge clock);
        chk("s3_stall", {31'd0, cpu_stall}, 32'd1);
        chk("s3_we", {31'd0, mem_we}, 32'd1);
        chk("s3_addr", mem_addr, 32'h40);
        chk("s3_wdata", mem_wdata, d);
        if (do_rst) begin
            reset = 1'b1;
            #1;
            chk("s6_stall_async", {31'd0, cpu_stall}, 32'd0);
            chk("s6_we_async", {31'd0, mem_we}, 32'd0);
            tick();
            @(negedge clock);
            chk("s6_no_ack", {31'd0, dma_ack}, 32'd0);
            chk("s6_mem_kept", dmem[8'h40], 32'h12345678);
            reset = 1'b0;
            drive_idle();
            tick();
        end else begin
            tick();
            @(negedge clock);
            chk("s3_ack", {31'd0, dma_ack}, 32'd1);
            chk("s3_stall_once", {31'd0, cpu_stall}, 32'd0);
            tick();
            drive_idle();
            @(negedge clock);
            chk("s3_mem_written", dmem[8'h40], d);
            tick();
        end
    endtask

    initial begin
        drive_idle();
        cpu_addr = 32'h1234; cpu_wdata = '0; dma_addr = '0; dma_wdata = '0;
        #1;
        do_reset();

        // Single-cycle mux decisions from IDLE
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 7; i++) begin
            cpu_access = vecs[i].ca; cpu_we = vecs[i].cw;
            dma_req = vecs[i].dr; dma_we = vecs[i].dw;
            cpu_addr = 32'h20; cpu_wdata = 32'hC000_0000 | i;
            dma_addr = 32'h30; dma_wdata = 32'hD000_0000 | i;
            @(negedge clock);
            chk($sformatf("vec%0d_we", i), {31'd0, mem_we}, {31'd0, vecs[i].exp_we});
            chk($sformatf("vec%0d_addr", i), mem_addr, vecs[i].exp_dma ? 32'h30 : 32'h20);
            chk($sformatf("vec%0d_wdata", i), mem_wdata,
                vecs[i].exp_dma ? (32'hD000_0000 | i) : (32'hC000_0000 | i));
            chk($sformatf("vec%0d_stall", i), {31'd0, cpu_stall}, 32'd0);
            tick();
            drive_idle();
            @(negedge clock);
            chk($sformatf("vec%0d_ack", i), {31'd0, dma_ack}, {31'd0, vecs[i].exp_dma});
            tick();
            tick();
        end

        // Best-case DMA read
        preload(8'h10, 32'hDEADBEEF);
        cpu_addr = 32'h99; dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h10;
        @(negedge clock);
        chk("s1_addr", mem_addr, 32'h10);
        chk("s1_stall", {31'd0, cpu_stall}, 32'd0);
        tick();
        @(negedge clock);
        chk("s1_ack", {31'd0, dma_ack}, 32'd1);
        chk("s1_rdata", dma_rdata, 32'hDEADBEEF);
        chk("s1_stall2", {31'd0, cpu_stall}, 32'd0);
        tick();
        drive_idle();
        tick();

        // DMA waits out a short CPU burst
        cpu_access = 1'b1; cpu_addr = 32'h44; dma_req = 1'b1; dma_addr = 32'h14;
        for (int c = 0; c < 5; c++) begin
            if (c >= 3) cpu_access = 1'b0;
            @(negedge clock);
            chk($sformatf("s2_addr_c%0d", c), mem_addr, (c == 3) ? 32'h14 : 32'h44);
            chk($sformatf("s2_stall_c%0d", c), {31'd0, cpu_stall}, 32'd0);
            chk($sformatf("s2_ack_c%0d", c), {31'd0, dma_ack}, (c == 4) ? 32'd1 : 32'd0);
            tick();
        end
        drive_idle();
        tick();

        scen3(1'b0, 32'h12345678);
        scen3(1'b1, 32'hCAFEF00D);
        scen3(1'b0, 32'h12345678);

        // Continuous DMA requests alternate grant and ack cycles
        cpu_access = 1'b0; cpu_addr = 32'h4C; dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h10;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            chk($sformatf("s4_addr_c%0d", c), mem_addr, (c % 2 == 0) ? 32'h10 : 32'h4C);
            chk($sformatf("s4_ack_c%0d", c), {31'd0, dma_ack}, (c % 2 == 1) ? 32'd1 : 32'd0);
            tick();
        end
        drive_idle();
        tick();

        // Unqualified cpu_we must not write
        preload(8'h50, 32'h55AA55AA);
        cpu_we = 1'b1; cpu_access = 1'b0; cpu_addr = 32'h50; cpu_wdata = 32'h0;
        @(negedge clock);
        chk("s5_we", {31'd0, mem_we}, 32'd0);
        tick();
        drive_idle();
        @(negedge clock);
        chk("s5_mem", dmem[8'h50], 32'h55AA55AA);
        tick();

        // Randomized traffic against a transaction-level reference
        for (int a = 128; a < 256; a++) begin
            ref_mem[a] = 32'(a) * 32'h01010101 ^ 32'hA5A5A5A5;
            preload(8'(a), ref_mem[a]);
        end
        do_reset();
        m_ack_cycle = 0; m_blocked = 0; m_ack_exp = 1'b0; m_rdata_exp = '0;
        hold_cpu = 0; dma_pending = 0;
        for (int n = 0; n < 600; n++) begin
            m_stall = !m_ack_cycle && (m_blocked == MAX_WAIT);
            if (!hold_cpu) begin
                cpu_access = ($urandom_range(0, 7) != 0);
                cpu_we     = 1'($urandom_range(0, 1));
                cpu_addr   = 32'h80 | 32'($urandom_range(0, 127));
                cpu_wdata  = $urandom;
            end
            if (dma_pending) begin
                if (!m_stall && !m_ack_cycle && $urandom_range(0, 15) == 0) begin
                    dma_pending = 0;
                    dma_req = 1'b0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                dma_pending = 1;
                dma_req   = 1'b1;
                dma_we    = 1'($urandom_range(0, 1));
                dma_addr  = 32'h80 | 32'($urandom_range(0, 127));
                dma_wdata = $urandom;
            end else begin
                dma_req = 1'b0;
            end

            @(negedge clock);
            m_grant = dma_req && !m_ack_cycle && (m_stall || !cpu_access);
            e_addr  = m_grant ? dma_addr : cpu_addr;
            e_wdata = m_grant ? dma_wdata : cpu_wdata;
            e_we    = m_grant ? dma_we : (cpu_we & cpu_access);
            chk("rnd_addr", mem_addr, e_addr);
            chk("rnd_wdata", mem_wdata, e_wdata);
            chk("rnd_we", {31'd0, mem_we}, {31'd0, e_we});
            chk("rnd_stall", {31'd0, cpu_stall}, {31'd0, m_stall});
            chk("rnd_ack", {31'd0, dma_ack}, {31'd0, m_ack_exp});
            chk("rnd_dma_rdata", dma_rdata, m_rdata_exp);
            chk("rnd_cpu_rdata", cpu_rdata, ref_mem[e_addr[7:0]]);

            m_ack_exp = m_grant;
            if (m_grant) m_rdata_exp = ref_mem[e_addr[7:0]];
            if (e_we) ref_mem[e_addr[7:0]] = e_wdata;
            if (m_grant || m_ack_cycle || !dma_req) m_blocked = 0;
            else if (cpu_access) m_blocked++;
            if (m_grant) dma_pending = 0;
            m_ack_cycle = m_grant;
            hold_cpu    = m_stall;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
